// File: rtl/mem_handshake_ram.sv
// Byte-addressable RAM behind MAR/MDR with an MFA/MOC four-phase handshake.
// Accesses complete LATENCY cycles after capture; big-endian multi-byte ordering.
module mem_handshake_ram #(
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 8
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              MFA,
    input  logic              RW,
    input  logic [1:0]        SIZE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [31:0]       DATA_IN,
    output logic [31:0]       DATA_OUT,
    output logic              MOC,
    output logic              BUSY,
    output logic              ALIGN_ERR
);

    localparam int         DEPTH    = 2 ** ADDR_W;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              rw_q;
    logic [1:0]        size_q;
    logic [31:0]       din_q;

    logic [7:0]        mem [DEPTH];

    logic [ADDR_W-1:0] a0, a1, a2, a3;
    logic              misalign;
    logic              do_access;
    logic [31:0]       rd_data;

    // Aligned accesses never cross the top of memory, so plain increments suffice.
    assign a0 = addr_q;
    assign a1 = addr_q + ADDR_W'(1);
    assign a2 = addr_q + ADDR_W'(2);
    assign a3 = addr_q + ADDR_W'(3);

    assign misalign  = (size_q == 2'b11) ||
                       (size_q == 2'b01 && addr_q[0]) ||
                       (size_q == 2'b10 && addr_q[1:0] != 2'b00);
    assign do_access = (state == S_WAIT) && (cnt == 4'd0);

    always_comb begin
        rd_data = 32'h0;
        case (size_q)
            2'b00:   rd_data = {24'h0, mem[a0]};
            2'b01:   rd_data = {16'h0, mem[a0], mem[a1]};
            default: rd_data = {mem[a0], mem[a1], mem[a2], mem[a3]};
        endcase
    end

    // Storage is deliberately not reset; reset forces IDLE, which blocks commits.
    always_ff @(posedge CLK) begin
        if (do_access && !rw_q && !misalign) begin
            case (size_q)
                2'b00: mem[a0] <= din_q[7:0];
                2'b01: begin
                    mem[a0] <= din_q[15:8];
                    mem[a1] <= din_q[7:0];
                end
                default: begin
                    mem[a0] <= din_q[31:24];
                    mem[a1] <= din_q[23:16];
                    mem[a2] <= din_q[15:8];
                    mem[a3] <= din_q[7:0];
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            addr_q    <= '0;
            rw_q      <= 1'b0;
            size_q    <= 2'b00;
            din_q     <= 32'h0;
            DATA_OUT  <= 32'h0;
            MOC       <= 1'b0;
            BUSY      <= 1'b0;
            ALIGN_ERR <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (MFA) begin
                        addr_q <= ADDR;
                        rw_q   <= RW;
                        size_q <= SIZE;
                        din_q  <= DATA_IN;
                        cnt    <= CNT_LOAD;
                        BUSY   <= 1'b1;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        MOC   <= 1'b1;
                        state <= S_DONE;
                        if (misalign) begin
                            ALIGN_ERR <= 1'b1;
                            DATA_OUT  <= 32'h0;
                        end else if (rw_q) begin
                            DATA_OUT <= rd_data;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    if (!MFA) begin
                        MOC       <= 1'b0;
                        ALIGN_ERR <= 1'b0;
                        BUSY      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_handshake_ram.md
Name: mem_handshake_ram

Overview:
- Byte-addressable 256-byte data/instruction memory directly downstream of the MAR/MDR pair in the datapath.
- Takes address from MAR (8 bits) and write data from MDR.
- Returns read data to the MDR input mux and to the instruction register.
- Multi-cycle latency with an MFA/MOC four-phase handshake, so the control unit must wait on MOC before latching IR/MDR.

Parameters:
LATENCY, 2, cycles from request capture to MOC rise; legal range 1..15
ADDR_W, 8, address width; depth = 2**ADDR_W bytes

Ports:
CLK  in  1  clock, rising-edge
CLR  in  1  asynchronous active-low reset
MFA  in  1  memory function activate (request), level, held until MOC seen
RW  in  1  1 = read, 0 = write
SIZE  in  2  00 byte, 01 halfword, 10 word, 11 illegal
ADDR  in  ADDR_W  byte address (from MAR)
DATA_IN  in  32  write data (from MDR)
DATA_OUT  out  32  read data
MOC  out  1  memory operation complete
BUSY  out  1  high whenever state is not IDLE
ALIGN_ERR  out  1  qualifies MOC: access was misaligned or SIZE illegal, no effect performed

Behaviour:
- Reset (CLR=0, asynchronous):
  - State goes to IDLE; MOC, BUSY, ALIGN_ERR = 0; DATA_OUT = 32'h0; latency counter = 0.
  - Storage array is not cleared.
  - A pending write is aborted and no bytes are modified.
- States: IDLE, WAIT, DONE.
- IDLE:
  - On a rising edge with MFA=1, latch ADDR, RW, SIZE and DATA_IN.
  - Load counter with LATENCY-1 and go to WAIT (BUSY=1 from this edge).
- WAIT:
  - Counter decrements each edge. All inputs are ignored; latched values are used.
  - On the edge where counter = 0, perform the access, set MOC=1, and go to DONE.
  - With LATENCY=1, MOC rises on the edge immediately after capture. In general MOC rises exactly LATENCY edges after the capture edge.
- DONE:
  - MOC stays 1 while MFA=1.
  - On an edge with MFA=0: MOC=0, ALIGN_ERR=0, go to IDLE.
  - A new request needs MFA sampled high in IDLE, so there is at least 1 idle cycle between transactions.
- Alignment:
  - Halfword requires ADDR[0]=0; word requires ADDR[1:0]=00; SIZE=11 is always an error.
  - On error: ALIGN_ERR=1 together with MOC, no write, DATA_OUT=32'h0.
- Byte order: big-endian. For a word at a: mem[a]→[31:24], mem[a+1]→[23:16], mem[a+2]→[15:8], mem[a+3]→[7:0].
- Reads:
  - Byte: zero-extended into [7:0].
  - Halfword: mem[a]→[15:8], mem[a+1]→[7:0], zero-extended.
  - DATA_OUT updates on the MOC-rise edge and holds until the next completed read or reset. Writes do not change DATA_OUT.
- Writes:
  - Byte: DATA_IN[7:0] goes to mem[a].
  - Halfword: DATA_IN[15:8]→mem[a], DATA_IN[7:0]→mem[a+1].
  - Word: big-endian as above.
  - Commit happens on the MOC-rise edge only.
- Address wrap cannot occur, since aligned multi-byte accesses never cross 255.
- Changing ADDR, DATA_IN or RW during WAIT or DONE has no effect.
- Dropping MFA during WAIT does not cancel the access: it completes, enters DONE, and returns to IDLE on the next edge.

Test Plan:
- LATENCY=2, word write 32'hE3A01005 at ADDR 8'h10, then word read at 8'h10 → write MOC rises 2 edges after capture; read DATA_OUT=32'hE3A01005; MOC falls 1 edge after MFA drops.
- After that word write, byte reads at 8'h10 and 8'h13 → DATA_OUT=32'h000000E3 and 32'h00000005; halfword read at 8'h12 → 32'h00001005.
- Halfword write 16'hBEEF at 8'h12, then word read at 8'h10 → 32'hE3A0BEEF.
- Word read at 8'h11 and SIZE=11 at 8'h10 → MOC=1 with ALIGN_ERR=1; DATA_OUT=0; memory at 8'h10 still reads 32'hE3A0BEEF.
- Word write 32'h12345678 to 8'h20, CLR pulsed low during WAIT → MOC, BUSY, DATA_OUT=0 immediately; subsequent read of 8'h20 returns its pre-write value.
- Hold MFA=1 across DONE for 5 cycles → MOC stays 1, no second access occurs; ADDR changed during WAIT is ignored (read returns data of the latched address).
